// File: rtl/dcs_ctrl.sv
// rtl/dcs_ctrl.sv - DCS clock-select sequencer: deselect gap, reselect, settle, report.
// Optional DCS_CTRL_KEY_EN adds a debounced key that steps to the next source.
module dcs_ctrl #(
    parameter int GAP_CYCLES      = 8,
    parameter int SETTLE_CYCLES   = 16,
    parameter int RESET_SEL       = 0,
    parameter int DEBOUNCE_CYCLES = 1350000
) (
    input  logic       clk,
    input  logic       rst_i,
`ifdef DCS_CTRL_KEY_EN
    input  logic       key_i,
`endif
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    input  logic [3:0] src_en,
    output logic [3:0] clksel,
    output logic       selforce,
    output logic [1:0] cur_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, DESEL, SETTLE} state_t;

    localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic [1:0] tgt;
    logic       acc_valid;
    logic [1:0] acc_sel;
    logic       accepted;
    logic       start_switch;

`ifdef DCS_CTRL_KEY_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            key_s1, key_s2, key_stable, key_stable_d;
    logic [DB_W-1:0] db_cnt;
    logic            key_edge;

    // Stable level only follows the synchronized key after a full window of disagreement.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            key_s1       <= 1'b0;
            key_s2       <= 1'b0;
            key_stable   <= 1'b0;
            key_stable_d <= 1'b0;
            db_cnt       <= '0;
        end else begin
            key_s1       <= key_i;
            key_s2       <= key_s1;
            key_stable_d <= key_stable;
            if (key_s2 == key_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                key_stable <= key_s2;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign key_edge = key_stable & ~key_stable_d;

    // An external request outranks a coincident key edge.
    always_comb begin
        acc_valid = req_valid | key_edge;
        acc_sel   = req_valid ? req_sel : cur_sel + 2'd1;
    end
`else
    assign acc_valid = req_valid;
    assign acc_sel   = req_sel;
`endif

    assign accepted     = acc_valid && (state == IDLE);
    assign start_switch = accepted && src_en[acc_sel] && (acc_sel != cur_sel);

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_switch)        state_nxt = DESEL;
            DESEL:   if (cnt == GAP_LAST)     state_nxt = SETTLE;
            SETTLE:  if (cnt == SETTLE_LAST)  state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            cnt     <= 8'd0;
            tgt     <= 2'(RESET_SEL);
            cur_sel <= 2'(RESET_SEL);
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (state != state_nxt)  cnt <= 8'd0;
            else if (state != IDLE)  cnt <= cnt + 8'd1;
            if (start_switch)        tgt <= acc_sel;
            if (state == DESEL && state_nxt == SETTLE) cur_sel <= tgt;
            done <= (accepted && src_en[acc_sel] && (acc_sel == cur_sel))
                 || (state == SETTLE && cnt == SETTLE_LAST);
            err  <= accepted && !src_en[acc_sel];
        end
    end

    // CLKSEL is forced to zero for the whole deselect gap.
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        selforce  = 1'b1;
        clksel    = (state == DESEL) ? 4'b0000 : (4'b0001 << cur_sel);
    end

endmodule

// File: tb/tb_dcs_ctrl.sv
// tb/tb_dcs_ctrl.sv - scoreboard bench for dcs_ctrl (key path when DCS_CTRL_KEY_EN is defined).
module tb_dcs_ctrl;
    localparam int GAP    = 8;
    localparam int SETTLE = 16;

    typedef struct {
        bit         is_err;
        int         cyc;
        logic [3:0] clksel;
        logic [1:0] cur_sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = 2'd0;
    logic [3:0] src_en = 4'b1111;
    logic       req_ready, selforce, busy, done, err;
    logic [3:0] clksel;
    logic [1:0] cur_sel;
`ifdef DCS_CTRL_KEY_EN
    logic       key_i = 1'b0;
`endif

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    dcs_ctrl #(
        .GAP_CYCLES(GAP), .SETTLE_CYCLES(SETTLE), .RESET_SEL(0), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst_i(rst_i),
`ifdef DCS_CTRL_KEY_EN
        .key_i(key_i),
`endif
        .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
        .src_en(src_en), .clksel(clksel), .selforce(selforce), .cur_sel(cur_sel),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_i) begin
            chk("done_err_exclusive", {31'd0, done & err}, 32'd0);
            chk("clksel_onehot_or_zero", {31'd0, $countones(clksel) <= 1}, 32'd1);
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got done=%0b err=%0b at cyc %0d, expected none",
                             done, err, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_err", {31'd0, err}, {31'd0, e.is_err});
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_clksel", {28'd0, clksel}, {28'd0, e.clksel});
                    chk("resp_cur_sel", {30'd0, cur_sel}, {30'd0, e.cur_sel});
                end
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b0;
        #1;
        chk("rst_clksel", {28'd0, clksel}, 32'h1);
        chk("rst_cur_sel", {30'd0, cur_sel}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
    endtask

    // kind: 0 no response expected, 1 done, 2 err; called just after a falling edge.
    task automatic issue(input logic [1:0] sel, input int kind, input int off,
                         input logic [3:0] ecs, input logic [1:0] ecur);
        exp_t e;
        if (kind != 0) begin
            e.is_err  = (kind == 2);
            e.cyc     = cyc + 1 + off;
            e.clksel  = ecs;
            e.cur_sel = ecur;
            exp_q.push_back(e);
        end
        req_sel   = sel;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic switch_ok(input logic [1:0] sel);
        logic [3:0] oh;
        oh = 4'b0001 << sel;
        issue(sel, 1, GAP + SETTLE, oh, sel);
        for (int i = 0; i < GAP; i++) begin
            chk("gap_clksel_zero", {28'd0, clksel}, 32'd0);
            chk("gap_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        chk("resel_clksel", {28'd0, clksel}, {28'd0, oh});
        chk("resel_cur_sel", {30'd0, cur_sel}, {30'd0, sel});
        chk("settle_ready", {31'd0, req_ready}, 32'd0);
        repeat (SETTLE + 1) @(negedge clk);
        chk("end_ready", {31'd0, req_ready}, 32'd1);
        chk("end_selforce", {31'd0, selforce}, 32'd1);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk("init_clksel", {28'd0, clksel}, 32'h1);
        chk("init_busy", {31'd0, busy}, 32'd0);

        switch_ok(2'd1);

        do_reset();
        src_en = 4'b1011;
        issue(2'd2, 2, 0, 4'b0001, 2'd0);
        @(negedge clk);
        chk("err_clksel_kept", {28'd0, clksel}, 32'h1);
        chk("err_ready", {31'd0, req_ready}, 32'd1);
        issue(2'd0, 1, 0, 4'b0001, 2'd0);
        @(negedge clk);
        src_en = 4'b1111;

        switch_ok(2'd3);

        do_reset();
        issue(2'd1, 1, GAP + SETTLE, 4'b0010, 2'd1);
        @(negedge clk);
        req_sel   = 2'd3;
        req_valid = 1'b1;
        src_en    = 4'b0000;
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        repeat (GAP + SETTLE + 2) @(negedge clk);
        src_en = 4'b1111;
        chk("busy_ignored_clksel", {28'd0, clksel}, 32'h2);
        chk("busy_ignored_cur_sel", {30'd0, cur_sel}, 32'd1);

        do_reset();
        issue(2'd2, 0, 0, 4'b0000, 2'd0);
        repeat (4) @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("abort_clksel", {28'd0, clksel}, 32'h1);
        chk("abort_cur_sel", {30'd0, cur_sel}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        repeat (GAP + SETTLE + 4) @(negedge clk);
        chk("abort_final_clksel", {28'd0, clksel}, 32'h1);

`ifdef DCS_CTRL_KEY_EN
        do_reset();
        key_i = 1'b1;
        repeat (2) @(negedge clk);
        key_i = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_clksel", {28'd0, clksel}, 32'h1);
        for (int p = 1; p <= 2; p++) begin
            exp_t e;
            e.is_err  = 1'b0;
            e.cyc     = cyc + 7 + GAP + SETTLE;
            e.clksel  = 4'b0001 << p;
            e.cur_sel = 2'(p);
            exp_q.push_back(e);
            key_i = 1'b1;
            repeat (10) @(negedge clk);
            key_i = 1'b0;
            repeat (GAP + SETTLE + 10) @(negedge clk);
            chk("key_cur_sel", {30'd0, cur_sel}, p);
        end
`endif

        repeat (5) @(negedge clk);
        chk("pending_resp", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dcs_ctrl.md
DCS_CTRL -- requirements
Module: dcs_ctrl

Interface
REQ-001 Parameter GAP_CYCLES, 8, cycles CLKSEL is held all-zero between deselect and reselect (1..255).
REQ-002 Parameter SETTLE_CYCLES, 16, cycles after reselect before a switch is reported complete (1..255).
REQ-003 Parameter RESET_SEL, 0, source index (0..3) selected out of reset.
REQ-004 Parameter DEBOUNCE_CYCLES, 1350000, key stability window (only with DCS_CTRL_KEY_EN).
REQ-005 clk  in  1  always-running controller clock, not routed through the DCS.
REQ-006 rst_i  in  1  asynchronous reset, active-low.
REQ-007 req_valid  in  1  switch request strobe.
REQ-008 req_sel  in  2  requested source index.
REQ-009 req_ready  out  1  controller idle, request accepted when req_valid && req_ready.
REQ-010 src_en  in  4  per-source enable mask; bit i low marks source i unusable.
REQ-011 clksel  out  4  one-hot or all-zero DCS CLKSEL drive.
REQ-012 selforce  out  1  DCS SELFORCE drive.
REQ-013 cur_sel  out  2  currently selected source index.
REQ-014 busy  out  1  switch sequence in progress.
REQ-015 done  out  1  one-cycle pulse, request completed.
REQ-016 err  out  1  one-cycle pulse, request rejected.

Function
REQ-017 FSM states IDLE, DESEL, SETTLE; DESEL→SETTLE after GAP_CYCLES cycles, SETTLE→IDLE after SETTLE_CYCLES cycles.
REQ-018 req_ready = (state==IDLE); busy = ~req_ready; selforce constant 1.
REQ-019 Accept in cycle N, req_sel != cur_sel, src_en[req_sel]=1: clksel=0 from N+1 to N+GAP_CYCLES inclusive.
REQ-020 clksel=onehot(req_sel) and cur_sel=req_sel from cycle N+1+GAP_CYCLES.
REQ-021 done pulses and req_ready rises in cycle N+1+GAP_CYCLES+SETTLE_CYCLES.
REQ-022 Accept with req_sel == cur_sel and source enabled: no state change, clksel unchanged, done pulses at N+1.
REQ-023 Accept with src_en[req_sel]=0: clksel/cur_sel unchanged, err pulses at N+1, FSM stays IDLE.
REQ-024 req_valid while busy is ignored (not queued); req_sel sampled only at acceptance.
REQ-025 src_en changes during DESEL/SETTLE do not abort the sequence.
REQ-026 done and err are never asserted in the same cycle; clksel never has more than one bit set.
REQ-027 Phase counters 8 bits wide, count 0..limit-1, no wrap beyond limit.

Reset
REQ-028 While rst_i=0: state IDLE, clksel=onehot(RESET_SEL), cur_sel=RESET_SEL, done=0, err=0, req_ready=1, counters 0.
REQ-029 Reset asserted mid-sequence immediately forces REQ-028 values; no partial switch completes.

Configuration
REQ-030 With DCS_CTRL_KEY_EN defined: input key_i (1 bit, active-high) added; synchronized by 2 flops, debounced over DEBOUNCE_CYCLES.
REQ-031 Each debounced rising edge in IDLE issues an internal request for (cur_sel+1) mod 4, handled per REQ-019..023.
REQ-032 Key edge while busy is dropped; key edge coinciding with req_valid in IDLE is dropped, req_valid wins.
REQ-033 Without DCS_CTRL_KEY_EN: no key_i port, no debounce logic; behaviour identical to REQ-017..029.

Verification (GAP_CYCLES=8, SETTLE_CYCLES=16, RESET_SEL=0, src_en=4'b1111 unless stated)
REQ-034 Release reset → clksel=4'b0001, cur_sel=0, req_ready=1, busy=0.
REQ-035 req_sel=1 accepted cycle 10 → clksel=0 cycles 11..18, 4'b0010 from 19, done at 35, no err.
REQ-036 src_en=4'b1011, req_sel=2 → err at N+1, clksel stays 4'b0001; req_sel=0 → done at N+1.
REQ-037 req_valid with req_sel=3 during DESEL of switch to 1 → ignored; final clksel=4'b0010.
REQ-038 rst_i low at cycle N+5 of a switch to 2 → clksel=4'b0001 immediately, no done pulse.
REQ-039 DCS_CTRL_KEY_EN, DEBOUNCE_CYCLES=4: 2-cycle glitch → no request; held press → switch 0→1 completes, second press → 1→2.
